// File: rtl/middle_ram_pkg.sv
// ----------------------------------------------------------------------------
// middle_ram_pkg: frame-buffer geometry shared by the pipeline stages. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package middle_ram_pkg;

  localparam int MID_COLS     = 128;
  localparam int MID_ROWS     = 128;
  localparam int MID_DATA_W   = 8;
  localparam int MID_COORD_W  = 8;
  localparam int MID_ADDR_W   = 14;
  localparam int MID_COL_BITS = $clog2(MID_COLS);
  localparam int MID_ROW_BITS = $clog2(MID_ROWS);

  // Row-major word address; callers must range-check first, this only truncates.
  function automatic logic [MID_ADDR_W-1:0] mid_addr(
    input logic [MID_COORD_W-1:0] col,
    input logic [MID_COORD_W-1:0] row
  );
    return {row[MID_ROW_BITS-1:0], col[MID_COL_BITS-1:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/middle_ram.sv
// ----------------------------------------------------------------------------
// middle_ram: simple dual-port block RAM, registered read-first read port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module middle_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
    rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/middle_ram_controller.sv
// ----------------------------------------------------------------------------
// middle_ram_controller: coordinate-addressed frame buffer with bounds checks. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module middle_ram_controller
  import middle_ram_pkg::*;
#(
  parameter int COLS    = MID_COLS,
  parameter int ROWS    = MID_ROWS,
  parameter int DATA_W  = MID_DATA_W,
  parameter int COORD_W = MID_COORD_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               iWren,
  input  logic [COORD_W-1:0] iWrcol,
  input  logic [COORD_W-1:0] iWrrow,
  input  logic [DATA_W-1:0]  iWrdata,
  input  logic [COORD_W-1:0] iRdcol,
  input  logic [COORD_W-1:0] iRdrow,
  output logic [DATA_W-1:0]  oRddata
);

  localparam int COL_BITS = $clog2(COLS);
  localparam int ROW_BITS = $clog2(ROWS);
  localparam int ADDR_W   = ROW_BITS + COL_BITS;

  localparam logic [COORD_W:0] COL_LIMIT = (COORD_W+1)'(COLS);
  localparam logic [COORD_W:0] ROW_LIMIT = (COORD_W+1)'(ROWS);

  logic              wr_in_range;
  logic              rd_in_range;
  logic              ram_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              rd_valid_d;
  logic              rd_valid_q;

  // Full-width compares keep out-of-range coordinates from aliasing after truncation.
  always_comb begin
    wr_in_range = ({1'b0, iWrcol} < COL_LIMIT) && ({1'b0, iWrrow} < ROW_LIMIT);
    rd_in_range = ({1'b0, iRdcol} < COL_LIMIT) && ({1'b0, iRdrow} < ROW_LIMIT);
    wr_addr     = {iWrrow[ROW_BITS-1:0], iWrcol[COL_BITS-1:0]};
    rd_addr     = {iRdrow[ROW_BITS-1:0], iRdcol[COL_BITS-1:0]};
    ram_we      = iWren & wr_in_range & reset_n;
    rd_valid_d  = rd_in_range;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
    end
  end

  middle_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clock),
    .i_we    (ram_we),
    .i_waddr (wr_addr),
    .i_wdata (iWrdata),
    .i_raddr (rd_addr),
    .o_rdata (ram_rdata)
  );

  // The RAM register has no reset; the cleared flag forces 0 out asynchronously.
  assign oRddata = rd_valid_q ? ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_middle_ram_controller.sv
// ----------------------------------------------------------------------------
// tb_middle_ram_controller: randomized bench against a behavioural frame model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_middle_ram_controller;

  logic       clock;
  logic       reset_n;
  logic       iWren;
  logic [7:0] iWrcol;
  logic [7:0] iWrrow;
  logic [7:0] iWrdata;
  logic [7:0] iRdcol;
  logic [7:0] iRdrow;
  logic [7:0] oRddata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model [0:16383];
  logic [7:0] exp_out;

  middle_ram_controller dut (
    .clock   (clock),
    .reset_n (reset_n),
    .iWren   (iWren),
    .iWrcol  (iWrcol),
    .iWrrow  (iWrrow),
    .iWrdata (iWrdata),
    .iRdcol  (iRdcol),
    .iRdrow  (iRdrow),
    .oRddata (oRddata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the following falling edge.
  task automatic cycle(input string tag, input logic we, input logic [7:0] wc,
                       input logic [7:0] wr, input logic [7:0] wd,
                       input logic [7:0] rc, input logic [7:0] rr);
    logic [7:0] exp_next;
    iWren = we; iWrcol = wc; iWrrow = wr; iWrdata = wd; iRdcol = rc; iRdrow = rr;
    #1 check({tag, "_hold"}, oRddata, exp_out);
    // Read-first: the read sees the frame as it was before this cycle's write.
    if (reset_n && rc < 128 && rr < 128) exp_next = model[int'(rr) * 128 + int'(rc)];
    else exp_next = 8'h00;
    if (reset_n && we && wc < 128 && wr < 128) model[int'(wr) * 128 + int'(wc)] = wd;
    @(posedge clock);
    #1 check(tag, oRddata, exp_next);
    exp_out = exp_next;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] wc, wr, rc, rr;
    reset_n = 1'b0;
    iWren = 1'b0; iWrcol = '0; iWrrow = '0; iWrdata = '0; iRdcol = '0; iRdrow = '0;
    for (int i = 0; i < 16384; i++) model[i] = 8'h00;
    exp_out = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_out", oRddata, 8'h00);
    reset_n = 1'b1;

    // Full 256x256 sweep; only the in-range quarter may land in the frame.
    for (int r = 0; r < 256; r++)
      for (int c = 0; c < 256; c++)
        cycle("ff_wr", 1'b1, 8'(c), 8'(r), 8'((r + c) & 8'hFF), 8'hFF, 8'hFF);
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++)
        cycle("ff_rd", 1'b0, 8'h00, 8'h00, 8'h00, 8'(c), 8'(r));
    // Independent of the model: (0,128) wrote 0x80 but (0,0) must still be 0x00.
    cycle("alias_rd", 1'b0, 8'h00, 8'h00, 8'h00, 8'd0, 8'd0);
    check("alias_00", oRddata, 8'h00);

    // Latency
    cycle("lat_wr", 1'b1, 8'd5, 8'd3, 8'hA5, 8'd0, 8'd0);
    cycle("lat_rd", 1'b0, 8'd0, 8'd0, 8'h00, 8'd5, 8'd3);
    check("lat_a5", oRddata, 8'hA5);

    // Read-during-write
    cycle("rdw_init", 1'b1, 8'd10, 8'd10, 8'h11, 8'd0, 8'd0);
    cycle("rdw_same", 1'b1, 8'd10, 8'd10, 8'h22, 8'd10, 8'd10);
    check("rdw_old", oRddata, 8'h11);
    cycle("rdw_next", 1'b0, 8'd0, 8'd0, 8'h00, 8'd10, 8'd10);
    check("rdw_new", oRddata, 8'h22);

    // Out-of-range read and disabled write
    cycle("oor_rd", 1'b0, 8'd0, 8'd0, 8'h00, 8'd200, 8'd4);
    check("oor_zero", oRddata, 8'h00);
    cycle("noen_wr", 1'b0, 8'd1, 8'd1, 8'hFF, 8'd0, 8'd0);
    cycle("noen_rd", 1'b0, 8'd0, 8'd0, 8'h00, 8'd1, 8'd1);
    check("noen_keep", oRddata, 8'h02);

    // Corners
    cycle("cor_w0", 1'b1, 8'd0,   8'd0,   8'h01, 8'd0, 8'd0);
    cycle("cor_w1", 1'b1, 8'd127, 8'd0,   8'h7F, 8'd0, 8'd0);
    cycle("cor_w2", 1'b1, 8'd0,   8'd127, 8'h80, 8'd0, 8'd0);
    cycle("cor_w3", 1'b1, 8'd127, 8'd127, 8'hFE, 8'd0, 8'd0);
    cycle("cor_r0", 1'b0, 8'd0, 8'd0, 8'h00, 8'd0,   8'd0);   check("cor_00",   oRddata, 8'h01);
    cycle("cor_r1", 1'b0, 8'd0, 8'd0, 8'h00, 8'd127, 8'd0);   check("cor_7f0",  oRddata, 8'h7F);
    cycle("cor_r2", 1'b0, 8'd0, 8'd0, 8'h00, 8'd0,   8'd127); check("cor_07f",  oRddata, 8'h80);
    cycle("cor_r3", 1'b0, 8'd0, 8'd0, 8'h00, 8'd127, 8'd127); check("cor_7f7f", oRddata, 8'hFE);

    // Asynchronous reset mid-stream, with writes attempted while held
    cycle("rst_pre", 1'b0, 8'd0, 8'd0, 8'h00, 8'd5, 8'd3);
    check("rst_pre_val", oRddata, 8'hA5);
    reset_n = 1'b0;
    #1 check("rst_async", oRddata, 8'h00);
    exp_out = 8'h00;
    cycle("rst_wr0", 1'b1, 8'd5,  8'd3,  8'h00, 8'd5, 8'd3);
    cycle("rst_wr1", 1'b1, 8'd10, 8'd10, 8'h99, 8'd5, 8'd3);
    cycle("rst_wr2", 1'b1, 8'd0,  8'd0,  8'h77, 8'd0, 8'd0);
    reset_n = 1'b1;
    cycle("rst_rd0", 1'b0, 8'd0, 8'd0, 8'h00, 8'd5,  8'd3);  check("rst_keep_53", oRddata, 8'hA5);
    cycle("rst_rd1", 1'b0, 8'd0, 8'd0, 8'h00, 8'd10, 8'd10); check("rst_keep_aa", oRddata, 8'h22);
    cycle("rst_rd2", 1'b0, 8'd0, 8'd0, 8'h00, 8'd0,  8'd0);  check("rst_keep_00", oRddata, 8'h01);

    // Random traffic, mostly in range, with frequent same-address collisions
    for (int i = 0; i < 1500; i++) begin
      wc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
      wr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
      if ($urandom_range(0, 4) == 0) begin
        rc = wc; rr = wr;
      end else begin
        rc = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
        rr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
      end
      cycle("rand", 1'($urandom_range(0, 1)), wc, wr, 8'($urandom), rc, rr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/middle_ram_controller.md
# middle_ram_controller

Coordinate-addressed frame buffer for the adaptive-thresholding pipeline: stores an intermediate 128×128 8-bit image between pipeline stages. The writer stage supplies (column, row, data) with a write enable; the reader stage independently supplies (column, row) and receives the stored pixel one clock later. The block wraps a simple dual-port RAM, adding address formation, bounds checking and a registered read output.

## Interface
Parameters:
- `COLS`, 128, image width in pixels (power of two)
- `ROWS`, 128, image height in pixels (power of two)
- `DATA_W`, 8, pixel width
- `COORD_W`, 8, width of coordinate inputs

Ports:
- `clock` in 1: the only clock; all logic is on the rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `iWren` in 1: write enable
- `iWrcol` in COORD_W: write column
- `iWrrow` in COORD_W: write row
- `iWrdata` in DATA_W: write pixel
- `iRdcol` in COORD_W: read column
- `iRdrow` in COORD_W: read row
- `oRddata` out DATA_W: read pixel, registered

## Operation
- Address: `addr = row[log2(ROWS)-1:0] * COLS + col[log2(COLS)-1:0]`, i.e. `{row[6:0], col[6:0]}`, which gives 16384 words.
- Write range check: the write commits only if `iWren=1`, `iWrcol < COLS` and `iWrrow < ROWS`.
  - Out-of-range writes are silently dropped. They must never alias onto in-range words, so truncating the upper coordinate bits is forbidden.
- Read range check: an out-of-range read (`iRdcol >= COLS` or `iRdrow >= ROWS`) returns 0.
- Read and write ports are fully independent. One write and one read may occur in every cycle.
- Read-during-write to the same address in the same cycle is read-first: `oRddata` returns the old contents. The new value is visible from the next read.
- Reset effects:
  - `oRddata` is cleared to 0.
  - The captured read-valid/range flag is cleared.
  - RAM contents are not cleared and are undefined after power-up.
- Writes are ignored while `reset_n=0`.

## Timing
- Write: committed at the rising edge where `iWren=1` and the address is in range. Sustained throughput is one pixel per clock.
- Read latency is one cycle. Read address presented before edge N gives `oRddata` valid after edge N, stable until edge N+1.
- One read per clock; back-to-back address changes each cycle are supported.
- `reset_n` asserts asynchronously: `oRddata` goes to 0 immediately.
- On deassertion, the first read is captured at the next rising edge.
- Reset asserted in the middle of a write stream: any edge seen while `reset_n=0` performs no write. Words written earlier are retained.
- No handshake and no stall: the block is always ready.

## Structure
- Shared package `middle_ram_pkg` holds the constants `MID_COLS=128`, `MID_ROWS=128`, `MID_DATA_W=8`, `MID_COORD_W=8` and `MID_ADDR_W=14`, plus an address-forming function or macro used by the writer and reader stages.
- One sub-module, `middle_ram`: a simple dual-port synchronous RAM, `2^ADDR_W × DATA_W`, with one write port and one registered read port, read-first. It must infer FPGA block RAM and must not have a reset on the array.
- The controller itself contains the bounds checks, address concatenation, the out-of-range read flag pipeline (one register, reset to 0) and the output mux/register.

## Test plan
- Full-frame write/readback: write all 256×256 coordinates with data `(row+col)&0xFF`, then read (col,row) for 0..127 × 0..127 one per cycle → every read equals `(row+col)&0xFF`. This proves out-of-range writes such as (0,128)=0x80 do not corrupt (0,0)=0x00.
- Latency: write (5,3)=0xA5. Present read (5,3) before edge N → `oRddata=0xA5` after edge N, and still the previous value before edge N.
- Read-during-write: (10,10) holds 0x11. In the same cycle, write 0x22 to it and read it → 0x11, and the next-cycle read → 0x22.
- Out-of-range read: read (200,4) → 0. Write with `iWren=0` to (1,1) → contents unchanged.
- Reset:
  - After reading a non-zero value, assert `reset_n=0` between edges → `oRddata=0` immediately.
  - Writes attempted during reset leave prior contents intact, checked by reading back after release.
- Corners: write and read (0,0), (127,0), (0,127) and (127,127) with distinct values (0x01, 0x7F, 0x80, 0xFE) → each reads back exactly.
